ep_tx_arb: RTL and testbench

Round-robin arbiter that shares the PCIe endpoint TRN transmit interface among up to NREQ requesters (mem_rd, tx completers, irq/msg generators). It grants one requester at a time via the req_ep/my_trn/drv_ep handshake and muxes that requester's TRN tx signals onto the endpoint. It also owns the shared 5-bit non-posted tag counter (tag_trn/tag_inc). It sits between the tx-side engines and the Virtex-5 PCIe block.

---
 rtl/ep_tx_arb.sv | 125 ++++++++++++
 tb/tb_ep_tx_arb.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ep_tx_arb.sv
// Round-robin owner of the endpoint TRN transmit interface: grants one requester
// at a time, muxes its TRN tx slice onto the endpoint and keeps the shared tag.
module ep_tx_arb #(
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_ep,
  input  logic [NREQ-1:0]      drv_ep,
  input  logic [NREQ-1:0]      tag_inc,
  output logic [NREQ-1:0]      my_trn,
  output logic [4:0]           tag_trn,
  input  logic [64*NREQ-1:0]   req_td,
  input  logic [8*NREQ-1:0]    req_trem_n,
  input  logic [NREQ-1:0]      req_tsof_n,
  input  logic [NREQ-1:0]      req_teof_n,
  input  logic [NREQ-1:0]      req_tsrc_rdy_n,
  output logic [63:0]          trn_td,
  output logic [7:0]           trn_trem_n,
  output logic                 trn_tsof_n,
  output logic                 trn_teof_n,
  output logic                 trn_tsrc_rdy_n,
  input  logic                 trn_tdst_rdy_n
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_nxt;
  logic [2:0]      gidx, ptr, sel;
  logic            found;
  logic [NREQ-1:0] grant_oh;
  logic [NREQ-1:0] drive_sel;
  logic            owner_busy;
  logic            owner_tag;
  logic            unused_tdst_rdy;

  // The endpoint ready is fanned out to requesters outside this block.
  assign unused_tdst_rdy = trn_tdst_rdy_n;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      grant_oh[i] = (gidx == 3'(i));
    end
  end

  assign owner_busy = |((req_ep | drv_ep) & grant_oh);
  assign owner_tag  = |(tag_inc & grant_oh);

  // Search ptr+1, ptr+2, ... (mod NREQ) so the last owner is considered last.
  always_comb begin
    sel   = ptr;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!found && req_ep[j] && (j == (int'(ptr) + k) % NREQ)) begin
          found = 1'b1;
          sel   = 3'(j);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found)       state_nxt = GRANT;
      GRANT:   if (!owner_busy) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    my_trn    = '0;
    drive_sel = '0;
    if (state == GRANT) begin
      my_trn    = grant_oh;
      drive_sel = grant_oh & drv_ep;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gidx <= 3'd0;
      ptr  <= 3'(NREQ - 1);
    end else if (state == IDLE && found) begin
      gidx <= sel;
      ptr  <= sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_trn <= 5'd0;
    end else if (state == GRANT && owner_tag) begin
      tag_trn <= tag_trn + 5'd1;
    end
  end

  // Idle values are driven unless the owner is actually driving its slice.
  always_comb begin
    trn_td         = 64'd0;
    trn_trem_n     = 8'hFF;
    trn_tsof_n     = 1'b1;
    trn_teof_n     = 1'b1;
    trn_tsrc_rdy_n = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (drive_sel[i]) begin
        trn_td         = req_td[i*64 +: 64];
        trn_trem_n     = req_trem_n[i*8 +: 8];
        trn_tsof_n     = req_tsof_n[i];
        trn_teof_n     = req_teof_n[i];
        trn_tsrc_rdy_n = req_tsrc_rdy_n[i];
      end
    end
  end

endmodule

// File: tb/tb_ep_tx_arb.sv
// Randomised and directed bench for ep_tx_arb against a cycle-level model of
// owner, round-robin pointer and tag counter.
module tb_ep_tx_arb;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_ep = '0, drv_ep = '0, tag_inc = '0;
  logic [N-1:0]  my_trn;
  logic [4:0]    tag_trn;
  logic [64*N-1:0] req_td = '0;
  logic [8*N-1:0]  req_trem_n = '0;
  logic [N-1:0]  req_tsof_n = '1, req_teof_n = '1, req_tsrc_rdy_n = '1;
  logic [63:0]   trn_td;
  logic [7:0]    trn_trem_n;
  logic          trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n;
  logic          trn_tdst_rdy_n = 1'b0;
  logic [74:0]   bus;

  int passed = 0;
  int total  = 0;

  int m_own = -1;
  int m_ptr = N - 1;
  int m_tag = 0;

  ep_tx_arb #(.NREQ(N)) dut (
    .clk(clk), .rst(rst), .req_ep(req_ep), .drv_ep(drv_ep), .tag_inc(tag_inc),
    .my_trn(my_trn), .tag_trn(tag_trn), .req_td(req_td), .req_trem_n(req_trem_n),
    .req_tsof_n(req_tsof_n), .req_teof_n(req_teof_n), .req_tsrc_rdy_n(req_tsrc_rdy_n),
    .trn_td(trn_td), .trn_trem_n(trn_trem_n), .trn_tsof_n(trn_tsof_n),
    .trn_teof_n(trn_teof_n), .trn_tsrc_rdy_n(trn_tsrc_rdy_n),
    .trn_tdst_rdy_n(trn_tdst_rdy_n)
  );

  assign bus = {trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n};

  always #5 clk = ~clk;

  function automatic bit bit_of(input logic [N-1:0] v, input int i);
    return v[i];
  endfunction

  // First requester after the last owner, walking the ring once.
  function automatic int winner(input int p, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      if (bit_of(r, (p + k) % N)) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_grant();
    if (m_own < 0) return '0;
    return N'(1 << m_own);
  endfunction

  function automatic logic [74:0] exp_bus();
    if (m_own >= 0 && bit_of(drv_ep, m_own))
      return {req_td[m_own*64 +: 64], req_trem_n[m_own*8 +: 8],
              req_tsof_n[m_own], req_teof_n[m_own], req_tsrc_rdy_n[m_own]};
    return {64'd0, 8'hFF, 3'b111};
  endfunction

  task automatic model_reset();
    m_own = -1;
    m_ptr = N - 1;
    m_tag = 0;
  endtask

  task automatic model_edge();
    int w;
    if (rst) begin
      model_reset();
    end else if (m_own < 0) begin
      w = winner(m_ptr, req_ep);
      if (w >= 0) begin
        m_own = w;
        m_ptr = w;
      end
    end else begin
      if (bit_of(tag_inc, m_own)) m_tag = (m_tag + 1) % 32;
      if (!bit_of(req_ep, m_own) && !bit_of(drv_ep, m_own)) m_own = -1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic randomize_data();
    for (int i = 0; i < 2*N; i++) req_td[i*32 +: 32] = $urandom;
    req_trem_n     = $urandom;
    req_tsof_n     = N'($urandom);
    req_teof_n     = N'($urandom);
    req_tsrc_rdy_n = N'($urandom);
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (my_trn !== 4'b0000) $display("[TB] FAIL reset_my_trn: got %b expected %b", my_trn, 4'b0000);
    else passed++;
    total++;
    if (tag_trn !== 5'd0) $display("[TB] FAIL reset_tag: got %0d expected 0", tag_trn);
    else passed++;
    total++;
    if (bus !== {64'd0, 8'hFF, 3'b111}) $display("[TB] FAIL reset_bus: got %h expected %h", bus, {64'd0, 8'hFF, 3'b111});
    else passed++;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    req_ep = 4'b0001;
    tick();
    total++;
    if (my_trn !== 4'b0001) $display("[TB] FAIL basic_grant: got %b expected 0001", my_trn);
    else passed++;
    randomize_data();
    drv_ep = 4'b0001;
    req_tsof_n[0] = 1'b0;
    req_tsrc_rdy_n[0] = 1'b0;
    #1;
    total++;
    if (trn_tsof_n !== 1'b0) $display("[TB] FAIL basic_tsof: got %b expected 0", trn_tsof_n);
    else passed++;
    total++;
    if (bus !== exp_bus()) $display("[TB] FAIL basic_mux: got %h expected %h", bus, exp_bus());
    else passed++;
    req_ep = '0;
    drv_ep = '0;
    tick();
    total++;
    if (my_trn !== 4'b0000) $display("[TB] FAIL basic_release: got %b expected 0000", my_trn);
    else passed++;
  endtask

  task automatic test_round_robin();
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int cnt = 0;
    logic [N-1:0] prev = '0;
    reset_dut();
    req_ep = 4'b1111;
    drv_ep = '0;
    for (int c = 0; c < 60 && order.size() < 5; c++) begin
      tick();
      total++;
      if (my_trn !== exp_grant()) $display("[TB] FAIL rr_grant: got %b expected %b", my_trn, exp_grant());
      else passed++;
      if (my_trn != 0 && prev == 0) begin
        for (int i = 0; i < N; i++) if (my_trn[i]) order.push_back(i);
      end
      prev   = my_trn;
      req_ep = 4'b1111;
      drv_ep = '0;
      if (m_own >= 0) begin
        cnt++;
        drv_ep = N'(1 << m_own);
        if (cnt == 3) begin
          req_ep[m_own] = 1'b0;
          drv_ep = '0;
          cnt = 0;
        end
      end
    end
    total++;
    if (order.size() != 5) $display("[TB] FAIL rr_count: got %0d grants expected 5", order.size());
    else passed++;
    for (int i = 0; i < 5; i++) begin
      if (i < order.size()) begin
        total++;
        if (order[i] != exp_order[i]) $display("[TB] FAIL rr_order[%0d]: got %0d expected %0d", i, order[i], exp_order[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_in_flight();
    req_ep = '0;
    drv_ep = '0;
    tick();
    tick();
    req_ep = 4'b0100;
    tick();
    total++;
    if (my_trn !== 4'b0100) $display("[TB] FAIL flight_grant2: got %b expected 0100", my_trn);
    else passed++;
    req_ep = 4'b0110;
    drv_ep = 4'b0100;
    tick();
    req_ep = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      tick();
      total++;
      if (my_trn !== 4'b0100) $display("[TB] FAIL flight_hold: got %b expected 0100", my_trn);
      else passed++;
    end
    drv_ep = '0;
    tick();
    total++;
    if (my_trn !== 4'b0000) $display("[TB] FAIL flight_idle: got %b expected 0000", my_trn);
    else passed++;
    tick();
    total++;
    if (my_trn !== 4'b0010) $display("[TB] FAIL flight_next: got %b expected 0010", my_trn);
    else passed++;
  endtask

  task automatic test_tag();
    req_ep = 4'b0010;
    drv_ep = 4'b0010;
    for (int k = 1; k <= 33; k++) begin
      tag_inc = 4'b0011;
      tick();
      tag_inc = 4'b0100;
      total++;
      if (tag_trn !== 5'(k % 32)) $display("[TB] FAIL tag_step: got %0d expected %0d", tag_trn, k % 32);
      else passed++;
      tick();
      tag_inc = '0;
      total++;
      if (tag_trn !== 5'(k % 32)) $display("[TB] FAIL tag_nonowner: got %0d expected %0d", tag_trn, k % 32);
      else passed++;
    end
  endtask

  task automatic test_no_drive();
    req_ep = 4'b0010;
    drv_ep = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      randomize_data();
      req_tsrc_rdy_n = '0;
      #1;
      total++;
      if (bus !== {64'd0, 8'hFF, 3'b111}) $display("[TB] FAIL nodrv_bus: got %h expected %h", bus, {64'd0, 8'hFF, 3'b111});
      else passed++;
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      req_ep  = N'($urandom) & N'($urandom);
      drv_ep  = N'($urandom) & N'($urandom);
      tag_inc = N'($urandom);
      randomize_data();
      #1;
      total++;
      if (bus !== exp_bus()) $display("[TB] FAIL rand_mux: got %h expected %h", bus, exp_bus());
      else passed++;
      tick();
      total++;
      if (my_trn !== exp_grant()) $display("[TB] FAIL rand_grant: got %b expected %b", my_trn, exp_grant());
      else passed++;
      total++;
      if (tag_trn !== 5'(m_tag)) $display("[TB] FAIL rand_tag: got %0d expected %0d", tag_trn, m_tag);
      else passed++;
    end
    tag_inc = '0;
  endtask

  task automatic test_reset_mid_packet();
    req_ep = '0;
    drv_ep = '0;
    tick();
    tick();
    req_ep = 4'b0010;
    tick();
    drv_ep = 4'b0010;
    req_tsrc_rdy_n = 4'b0000;
    req_tsof_n = 4'b0000;
    #1;
    total++;
    if (trn_tsrc_rdy_n !== 1'b0) $display("[TB] FAIL mid_active: got %b expected 0", trn_tsrc_rdy_n);
    else passed++;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (my_trn !== 4'b0000) $display("[TB] FAIL mid_rst_grant: got %b expected 0000", my_trn);
    else passed++;
    total++;
    if (trn_tsrc_rdy_n !== 1'b1) $display("[TB] FAIL mid_rst_tsrc: got %b expected 1", trn_tsrc_rdy_n);
    else passed++;
    total++;
    if (tag_trn !== 5'd0) $display("[TB] FAIL mid_rst_tag: got %0d expected 0", tag_trn);
    else passed++;
    req_ep = '0;
    drv_ep = '0;
    rst = 1'b0;
    model_reset();
    tick();
    req_ep = 4'b0110;
    tick();
    total++;
    if (my_trn !== 4'b0010) $display("[TB] FAIL mid_first_after: got %b expected 0010", my_trn);
    else passed++;
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_basic();
    test_round_robin();
    test_in_flight();
    test_tag();
    test_no_drive();
    test_random();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
